ghr_ckpt: RTL and testbench

GHR_CKPT -- requirements
Module: ghr_ckpt

---
 rtl/ghr_ckpt.sv | 120 ++++++++++++
 tb/tb_ghr_ckpt.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ghr_ckpt.sv
// Global-history checkpoint FIFO: snapshots history per predicted branch, restores it on mispredict.
// Latency: push/pop take effect at the next edge; restore strobe and corrected history appear one cycle after the resolving pop.
// Backpressure: pred_ready drops when full (unless a pop frees a slot) and for the single RECOVER cycle.
module ghr_ckpt #(
   parameter int HIST_W = 14,
   parameter int DEPTH  = 8    // power of two, >= 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     pred_valid,
   input  logic [HIST_W-1:0]        pred_hist,
   input  logic                     pred_taken,
   output logic                     pred_ready,
   input  logic                     res_valid,
   input  logic                     res_taken,
   output logic                     rec_en,
   output logic [HIST_W-1:0]        rec_data,
   output logic                     mispred,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     err
);

   localparam int            AW     = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_C = (AW+1)'(DEPTH);

   typedef enum logic {RUN, RECOVER} state_t;

   state_t              state_q;
   logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [AW:0]         count_q, count_d;
   logic                rec_en_q, mispred_q, err_q;
   logic [HIST_W-1:0]   rec_data_q;

   logic [HIST_W-1:0]   hist_mem  [DEPTH];
   logic                taken_mem [DEPTH];

   logic in_run, is_empty, not_full;
   logic pop_elig, mis_pop, push;
   logic underflow, overflow, res_in_recover;

   // Handshake decode: a pop is only considered in RUN with something queued;
   // a mispredicting pop flushes everything, including a same-cycle push.
   assign in_run         = (state_q == RUN);
   assign is_empty       = (count_q == '0);
   assign not_full       = (count_q != FULL_C);
   assign pop_elig       = res_valid && !is_empty && in_run;
   assign mis_pop        = pop_elig && (taken_mem[rd_ptr_q] != res_taken);
   assign pred_ready     = in_run && (not_full || pop_elig);
   assign push           = pred_valid && pred_ready && !mis_pop;
   assign underflow      = res_valid && is_empty && in_run;
   assign overflow       = pred_valid && !not_full && !pop_elig;
   assign res_in_recover = res_valid && !in_run;

   // Next pointers and occupancy; flush makes read catch up with write.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (mis_pop) begin
         rd_ptr_d = wr_ptr_q;
         count_d  = '0;
      end else begin
         if (push)     wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop_elig) rd_ptr_d = rd_ptr_q + AW'(1);
         case ({push, pop_elig})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control FSM with registered restore outputs, pointers and sticky error.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= RUN;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rec_en_q   <= 1'b0;
         mispred_q  <= 1'b0;
         err_q      <= 1'b0;
         rec_data_q <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         rec_en_q  <= mis_pop;
         mispred_q <= mis_pop;
         // Corrected history: checkpoint shifted left by one with the real outcome.
         if (mis_pop)
            rec_data_q <= HIST_W'({hist_mem[rd_ptr_q], res_taken});
         if (underflow || overflow || res_in_recover)
            err_q <= 1'b1;
         case (state_q)
            RUN:     if (mis_pop) state_q <= RECOVER;
            RECOVER: state_q <= RUN;
            default: state_q <= RUN;
         endcase
      end
   end

   // Checkpoint storage; contents need no reset since pointers gate validity.
   always_ff @(posedge clk) begin
      if (push) begin
         hist_mem[wr_ptr_q]  <= pred_hist;
         taken_mem[wr_ptr_q] <= pred_taken;
      end
   end

   assign rec_en   = rec_en_q;
   assign mispred  = mispred_q;
   assign rec_data = rec_data_q;
   assign count    = count_q;
   assign empty    = is_empty;
   assign err      = err_q;

endmodule

// File: tb/tb_ghr_ckpt.sv
// Directed bench for ghr_ckpt: one task per scenario, inline comparisons.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
// Summary line reports comparisons made and mismatches found.
module tb_ghr_ckpt;

   logic        clk = 1'b0;
   logic        reset;
   logic        pred_valid;
   logic [13:0] pred_hist;
   logic        pred_taken;
   logic        pred_ready;
   logic        res_valid;
   logic        res_taken;
   logic        rec_en;
   logic [13:0] rec_data;
   logic        mispred;
   logic [3:0]  count;
   logic        empty;
   logic        err;

   int n_cmp = 0;
   int n_bad = 0;

   ghr_ckpt #(.HIST_W(14), .DEPTH(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .pred_valid (pred_valid),
      .pred_hist  (pred_hist),
      .pred_taken (pred_taken),
      .pred_ready (pred_ready),
      .res_valid  (res_valid),
      .res_taken  (res_taken),
      .rec_en     (rec_en),
      .rec_data   (rec_data),
      .mispred    (mispred),
      .count      (count),
      .empty      (empty),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      pred_valid = 1'b0;
      pred_hist  = '0;
      pred_taken = 1'b0;
      res_valid  = 1'b0;
      res_taken  = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic push_one(input logic [13:0] h, input logic t);
      pred_valid = 1'b1;
      pred_hist  = h;
      pred_taken = t;
      tick();
      idle();
   endtask

   task automatic resolve(input logic t);
      res_valid = 1'b1;
      res_taken = t;
      tick();
      idle();
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (count !== 4'd0)      begin n_bad++; $display("FAIL reset_count got %0d exp 0", count); end
      n_cmp++; if (empty !== 1'b1)      begin n_bad++; $display("FAIL reset_empty got %b exp 1", empty); end
      n_cmp++; if (rec_en !== 1'b0)     begin n_bad++; $display("FAIL reset_rec_en got %b exp 0", rec_en); end
      n_cmp++; if (mispred !== 1'b0)    begin n_bad++; $display("FAIL reset_mispred got %b exp 0", mispred); end
      n_cmp++; if (err !== 1'b0)        begin n_bad++; $display("FAIL reset_err got %b exp 0", err); end
      n_cmp++; if (rec_data !== 14'h0)  begin n_bad++; $display("FAIL reset_rec_data got %h exp 0", rec_data); end
      n_cmp++; if (pred_ready !== 1'b1) begin n_bad++; $display("FAIL reset_pred_ready got %b exp 1", pred_ready); end
   endtask

   task automatic test_basic();
      logic       rt [3];
      logic [3:0] ec [3];
      rt = '{1'b1, 1'b0, 1'b1};
      ec = '{4'd2, 4'd1, 4'd0};
      do_reset();
      push_one(14'h0001, 1'b1);
      push_one(14'h0003, 1'b0);
      push_one(14'h0006, 1'b1);
      n_cmp++; if (count !== 4'd3) begin n_bad++; $display("FAIL basic_fill_count got %0d exp 3", count); end
      for (int i = 0; i < 3; i++) begin
         resolve(rt[i]);
         n_cmp++; if (count !== ec[i]) begin n_bad++; $display("FAIL basic_pop%0d_count got %0d exp %0d", i, count, ec[i]); end
         n_cmp++; if (rec_en !== 1'b0) begin n_bad++; $display("FAIL basic_pop%0d_rec_en got %b exp 0", i, rec_en); end
      end
      n_cmp++; if (err !== 1'b0)   begin n_bad++; $display("FAIL basic_err got %b exp 0", err); end
      n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL basic_empty got %b exp 1", empty); end
   endtask

   task automatic test_mispredict();
      do_reset();
      push_one(14'h1ABC, 1'b1);
      resolve(1'b0);
      // N+1
      n_cmp++; if (rec_en !== 1'b1)       begin n_bad++; $display("FAIL mis_rec_en got %b exp 1", rec_en); end
      n_cmp++; if (mispred !== 1'b1)      begin n_bad++; $display("FAIL mis_mispred got %b exp 1", mispred); end
      n_cmp++; if (rec_data !== 14'h3578) begin n_bad++; $display("FAIL mis_rec_data got %h exp 3578", rec_data); end
      n_cmp++; if (count !== 4'd0)        begin n_bad++; $display("FAIL mis_count got %0d exp 0", count); end
      n_cmp++; if (pred_ready !== 1'b0)   begin n_bad++; $display("FAIL mis_ready_n1 got %b exp 0", pred_ready); end
      tick();
      // N+2
      n_cmp++; if (pred_ready !== 1'b1)   begin n_bad++; $display("FAIL mis_ready_n2 got %b exp 1", pred_ready); end
      n_cmp++; if (rec_en !== 1'b0)       begin n_bad++; $display("FAIL mis_rec_en_n2 got %b exp 0", rec_en); end
      n_cmp++; if (mispred !== 1'b0)      begin n_bad++; $display("FAIL mis_mispred_n2 got %b exp 0", mispred); end
      n_cmp++; if (rec_data !== 14'h3578) begin n_bad++; $display("FAIL mis_rec_data_hold got %h exp 3578", rec_data); end
   endtask

   task automatic test_full();
      do_reset();
      for (int i = 0; i < 8; i++) push_one(14'(16 + i), 1'b0);
      n_cmp++; if (count !== 4'd8)      begin n_bad++; $display("FAIL full_count got %0d exp 8", count); end
      n_cmp++; if (pred_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready got %b exp 0", pred_ready); end
      // push plus correct pop while full
      pred_valid = 1'b1; pred_hist = 14'h2222; pred_taken = 1'b0;
      res_valid  = 1'b1; res_taken = 1'b0;
      #1;
      n_cmp++; if (pred_ready !== 1'b1) begin n_bad++; $display("FAIL full_ready_with_pop got %b exp 1", pred_ready); end
      tick();
      idle();
      n_cmp++; if (count !== 4'd8) begin n_bad++; $display("FAIL full_pushpop_count got %0d exp 8", count); end
      n_cmp++; if (err !== 1'b0)   begin n_bad++; $display("FAIL full_pushpop_err got %b exp 0", err); end
      // ninth push, no pop
      push_one(14'h3FFF, 1'b1);
      n_cmp++; if (err !== 1'b1)   begin n_bad++; $display("FAIL overflow_err got %b exp 1", err); end
      n_cmp++; if (count !== 4'd8) begin n_bad++; $display("FAIL overflow_count got %0d exp 8", count); end
      // head must now be hist 17 (entry 16 was popped): mispredict it to expose it
      resolve(1'b1);
      n_cmp++; if (rec_data !== 14'h0023) begin n_bad++; $display("FAIL full_head_order got %h exp 0023", rec_data); end
      tick();
   endtask

   task automatic test_wrap();
      logic [13:0] qh[$];
      logic        qt[$];
      logic [13:0] hh;
      logic        rt;
      logic [13:0] expd;
      int          v;
      do_reset();
      for (int k = 0; k < 5; k++) begin
         v = 256 + k * 37;
         push_one(v[13:0], (k % 3) == 0);
         qh.push_back(v[13:0]);
         qt.push_back((k % 3) == 0);
      end
      for (int i = 0; i < 20; i++) begin
         int k;
         k = 5 + i;
         v = 256 + k * 37;
         pred_valid = 1'b1; pred_hist = v[13:0]; pred_taken = (k % 3) == 0;
         res_valid  = 1'b1; res_taken = qt[0];
         tick();
         idle();
         void'(qh.pop_front());
         void'(qt.pop_front());
         qh.push_back(v[13:0]);
         qt.push_back((k % 3) == 0);
         n_cmp++; if (count !== 4'd5)  begin n_bad++; $display("FAIL wrap%0d_count got %0d exp 5", i, count); end
         n_cmp++; if (rec_en !== 1'b0) begin n_bad++; $display("FAIL wrap%0d_rec_en got %b exp 0", i, rec_en); end
      end
      hh   = qh[0];
      rt   = ~qt[0];
      expd = {hh[12:0], rt};
      resolve(rt);
      n_cmp++; if (rec_data !== expd) begin n_bad++; $display("FAIL wrap_head_hist got %h exp %h", rec_data, expd); end
      n_cmp++; if (count !== 4'd0)    begin n_bad++; $display("FAIL wrap_flush_count got %0d exp 0", count); end
      tick();
   endtask

   task automatic test_underflow();
      do_reset();
      resolve(1'b1);
      n_cmp++; if (err !== 1'b1)   begin n_bad++; $display("FAIL underflow_err got %b exp 1", err); end
      n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL underflow_count got %0d exp 0", count); end
      n_cmp++; if (rec_en !== 1'b0) begin n_bad++; $display("FAIL underflow_rec_en got %b exp 0", rec_en); end
   endtask

   task automatic test_flush();
      do_reset();
      push_one(14'h0AAA, 1'b1);
      push_one(14'h0555, 1'b0);
      // mispredict on head with a simultaneous wrong-path push
      res_valid  = 1'b1; res_taken = 1'b0;
      pred_valid = 1'b1; pred_hist = 14'h3333; pred_taken = 1'b1;
      tick();
      pred_valid = 1'b0;
      // N+1: res_valid kept high while recovering
      n_cmp++; if (count !== 4'd0)        begin n_bad++; $display("FAIL flush_count got %0d exp 0", count); end
      n_cmp++; if (rec_en !== 1'b1)       begin n_bad++; $display("FAIL flush_rec_en got %b exp 1", rec_en); end
      n_cmp++; if (rec_data !== 14'h1554) begin n_bad++; $display("FAIL flush_rec_data got %h exp 1554", rec_data); end
      n_cmp++; if (err !== 1'b0)          begin n_bad++; $display("FAIL flush_err_pre got %b exp 0", err); end
      tick();
      idle();
      n_cmp++; if (err !== 1'b1)   begin n_bad++; $display("FAIL recover_res_err got %b exp 1", err); end
      n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL flush_discard_count got %0d exp 0", count); end
      // reset while in RECOVER
      push_one(14'h0F0F, 1'b1);
      resolve(1'b0);
      n_cmp++; if (rec_en !== 1'b1) begin n_bad++; $display("FAIL rst_rec_pre_rec_en got %b exp 1", rec_en); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_cmp++; if (count !== 4'd0)      begin n_bad++; $display("FAIL rst_rec_count got %0d exp 0", count); end
      n_cmp++; if (rec_en !== 1'b0)     begin n_bad++; $display("FAIL rst_rec_rec_en got %b exp 0", rec_en); end
      n_cmp++; if (err !== 1'b0)        begin n_bad++; $display("FAIL rst_rec_err got %b exp 0", err); end
      n_cmp++; if (pred_ready !== 1'b1) begin n_bad++; $display("FAIL rst_rec_ready got %b exp 1", pred_ready); end
   endtask

   initial begin
      reset = 1'b1;
      idle();
      test_reset();
      test_basic();
      test_mispredict();
      test_full();
      test_wrap();
      test_underflow();
      test_flush();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
